// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and bubble insertion.
// Define PIPE_STAGE_SKID_EN to add a skid entry behind the head (registered in_ready).
module pipe_stage_reg #(
  parameter int                    CTRL_WIDTH  = 10,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  head_valid_q, head_valid_d;
  logic [CTRL_WIDTH-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  accept;
  logic                  xfer;

  assign accept    = in_valid & in_ready;
  assign xfer      = head_valid_q & out_ready;
  assign out_valid = head_valid_q;
  assign out_ctrl  = head_valid_q ? head_ctrl_q : CTRL_BUBBLE;
  assign out_data  = head_data_q;

`ifdef PIPE_STAGE_SKID_EN
  logic                  skid_valid_q, skid_valid_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  assign in_ready = ~skid_valid_q;

  always_comb begin
    head_valid_d = head_valid_q;
    head_ctrl_d  = head_ctrl_q;
    head_data_d  = head_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so only the skid-to-head move can happen
      if (xfer) begin
        head_ctrl_d  = skid_ctrl_q;
        head_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!head_valid_q || xfer) begin
        head_valid_d = 1'b1;
        head_ctrl_d  = in_ctrl;
        head_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end
    end else if (xfer) begin
      head_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign in_ready = ~head_valid_q | out_ready;

  always_comb begin
    head_valid_d = head_valid_q;
    head_ctrl_d  = head_ctrl_q;
    head_data_d  = head_data_q;
    if (flush) begin
      head_valid_d = 1'b0;
    end else if (accept) begin
      // covers the replace case: accept and transfer on the same edge
      head_valid_d = 1'b1;
      head_ctrl_d  = in_ctrl;
      head_data_d  = in_data;
    end else if (xfer) begin
      head_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_valid_q <= 1'b0;
      head_ctrl_q  <= '0;
      head_data_q  <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_ctrl_q  <= head_ctrl_d;
      head_data_q  <= head_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, corner sequences, random scoreboard.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int CW = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .CTRL_BUBBLE('0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
  );

  typedef struct {
    logic          rst_n;
    logic          in_valid;
    logic          flush;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          chk;
    logic          dchk;
    logic          exp_valid;
    logic          exp_ready;
    logic [CW-1:0] exp_ctrl;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic iv, input logic fl, input logic ordy,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    @(negedge clk);
    rst_n = r; in_valid = iv; flush = fl; out_ready = ordy; in_ctrl = c; in_data = d;
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [CW-1:0] c, input logic rdy);
    check({name, ".out_valid"}, {63'd0, out_valid}, {63'd0, v});
    check({name, ".out_ctrl"}, {54'd0, out_ctrl}, {54'd0, c});
    check({name, ".in_ready"}, {63'd0, in_ready}, {63'd0, rdy});
  endtask

  logic [CW+DW-1:0] sb[$];
  logic             prev_stall;
  logic [CW-1:0]    prev_ctrl;
  logic [DW-1:0]    prev_data;
  logic [CW+DW-1:0] head;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;

    // Reset, then stream 0x001..0x005 with out_ready held high.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 64'h0,    1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 64'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 10'h001, 64'h1001, 1'b1, 1'b1, 1'b0, 1'b1, 10'h000, 64'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 10'h002, 64'h1002, 1'b1, 1'b1, 1'b1, 1'b1, 10'h001, 64'h1001};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 10'h003, 64'h1003, 1'b1, 1'b1, 1'b1, 1'b1, 10'h002, 64'h1002};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 10'h004, 64'h1004, 1'b1, 1'b1, 1'b1, 1'b1, 10'h003, 64'h1003};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 10'h005, 64'h1005, 1'b1, 1'b1, 1'b1, 1'b1, 10'h004, 64'h1004};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 64'h0,    1'b1, 1'b1, 1'b1, 1'b1, 10'h005, 64'h1005};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 64'h0,    1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 64'h0};

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rst_n, vecs[i].in_valid, vecs[i].flush, vecs[i].out_ready,
            vecs[i].in_ctrl, vecs[i].in_data);
      if (vecs[i].chk) begin
        expect_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ctrl, vecs[i].exp_ready);
        if (vecs[i].dchk) check($sformatf("vec%0d.out_data", i), out_data, vecs[i].exp_data);
      end
    end

    // Backpressure: head 0x0AA stalled while 0x0BB is offered.
    drive(1, 1, 0, 0, 10'h0AA, 64'hAA);
    expect_out("bp0", 1'b0, 10'h000, 1'b1);
    drive(1, 1, 0, 0, 10'h0BB, 64'hBB);
    expect_out("bp1", 1'b1, 10'h0AA, SKID);
    drive(1, 1, 0, 0, 10'h0BB, 64'hBB);
    expect_out("bp2", 1'b1, 10'h0AA, 1'b0);
    check("bp2.out_data", out_data, 64'hAA);
    drive(1, SKID ? 1'b0 : 1'b1, 0, 1, 10'h0BB, 64'hBB);
    expect_out("bp3", 1'b1, 10'h0AA, ~SKID);
    drive(1, 0, 0, 1, 10'h000, 64'h0);
    expect_out("bp4", 1'b1, 10'h0BB, 1'b1);
    check("bp4.out_data", out_data, 64'hBB);
    drive(1, 0, 0, 1, 10'h000, 64'h0);
    expect_out("bp5", 1'b0, 10'h000, 1'b1);

    // Flush with a full stage and a simultaneous offer of 0x3FF.
    drive(1, 1, 0, 0, 10'h101, 64'h101);
    drive(1, 1, 0, 0, 10'h102, 64'h102);
    expect_out("fl1", 1'b1, 10'h101, SKID);
    drive(1, 1, 1, 0, 10'h3FF, 64'h3FF);
    expect_out("fl2", 1'b1, 10'h101, 1'b0);
    drive(1, 0, 0, 0, 10'h000, 64'h0);
    expect_out("fl3", 1'b0, 10'h000, 1'b1);
    drive(1, 0, 0, 1, 10'h000, 64'h0);
    expect_out("fl4", 1'b0, 10'h000, 1'b1);

    // Reset while stalled with a valid head.
    drive(1, 1, 0, 0, 10'h0CC, 64'hDEAD_BEEF);
    drive(0, 0, 0, 0, 10'h000, 64'h0);
    expect_out("rs0", 1'b1, 10'h0CC, SKID);
    drive(1, 0, 0, 0, 10'h000, 64'h0);
    expect_out("rs1", 1'b0, 10'h000, 1'b1);
    check("rs1.out_data", out_data, 64'h0);

    // Random traffic against a FIFO scoreboard.
    prev_stall = 1'b0; prev_ctrl = '0; prev_data = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic          iv;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      iv = 1'($urandom_range(0, 1));
      c  = CW'($urandom);
      d  = {$urandom, $urandom};
      if (!iv) begin c = 'x; d = 'x; end
      drive(1, iv, 0, 1'($urandom_range(0, 1)), c, d);
      check("rnd.out_valid", {63'd0, out_valid}, {63'd0, sb.size() > 0});
      if (SKID) check("rnd.in_ready", {63'd0, in_ready}, {63'd0, sb.size() < 2});
      else      check("rnd.in_ready", {63'd0, in_ready}, {63'd0, (sb.size() == 0) || out_ready});
      if (!out_valid) check("rnd.bubble", {54'd0, out_ctrl}, 64'd0);
      if (prev_stall) begin
        check("rnd.hold_ctrl", {54'd0, out_ctrl}, {54'd0, prev_ctrl});
        check("rnd.hold_data", out_data, prev_data);
      end
      if (out_valid && sb.size() > 0) begin
        head = sb[0];
        check("rnd.order_ctrl", {54'd0, out_ctrl}, {54'd0, head[CW+DW-1:DW]});
        check("rnd.order_data", out_data, head[DW-1:0]);
      end
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
      prev_stall = out_valid && !out_ready;
      prev_ctrl  = out_ctrl;
      prev_data  = out_data;
    end

    // Drain and confirm nothing is left or duplicated.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, 10'h000, 64'h0);
      if (out_valid && sb.size() > 0) begin
        head = sb[0];
        check("drain.ctrl", {54'd0, out_ctrl}, {54'd0, head[CW+DW-1:DW]});
        void'(sb.pop_front());
      end else begin
        check("drain.extra", {63'd0, out_valid}, 64'd0);
      end
    end
    check("drain.empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter: CTRL_WIDTH, 10, width of the control bundle (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc).
REQ-002 SHALL have parameter: DATA_WIDTH, 32, width of the datapath bundle.
REQ-003 SHALL have parameter: CTRL_BUBBLE, all zeros, control value presented when no valid entry is held.
REQ-004 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port: in_valid  input  1  upstream stage offers an entry.
REQ-007 SHALL have port: in_ready  output  1  block accepts the entry this cycle.
REQ-008 SHALL have port: in_ctrl  input  CTRL_WIDTH  control bundle of the offered entry.
REQ-009 SHALL have port: in_data  input  DATA_WIDTH  data bundle of the offered entry.
REQ-010 SHALL have port: flush  input  1  discard all held entries and the offered entry.
REQ-011 SHALL have port: out_valid  output  1  downstream entry valid.
REQ-012 SHALL have port: out_ready  input  1  downstream consumes the entry this cycle.
REQ-013 SHALL have port: out_ctrl  output  CTRL_WIDTH  control bundle of the head entry, CTRL_BUBBLE when out_valid=0.
REQ-014 SHALL have port: out_data  output  DATA_WIDTH  data bundle of the head entry.

Function
REQ-015 SHALL accept an entry only on a cycle with in_valid=1 and in_ready=1; transfer out only on out_valid=1 and out_ready=1.
REQ-016 SHALL have latency of exactly one cycle from acceptance to out_valid=1 when the block is empty.
REQ-017 SHALL preserve entry order; no entry duplicated or dropped except by flush.
REQ-018 SHALL hold out_valid, out_ctrl, out_data stable while out_valid=1 and out_ready=0.
REQ-019 SHALL drive out_ctrl=CTRL_BUBBLE combinationally whenever out_valid=0; out_data retains its last value (don't-care).
REQ-020 SHALL, on flush=1, clear all held entries at the next edge (out_valid=0, skid empty), ignore in_valid that cycle, and take priority over any simultaneous accept or transfer.
REQ-021 SHALL treat a simultaneous accept and transfer on a full single-entry head as a replace: the new entry becomes head, occupancy unchanged.
REQ-022 SHALL produce output and state with no X propagation when in_ctrl/in_data are X while in_valid=0.

Reset
REQ-023 SHALL, with rst_n=0 at a rising edge, set out_valid=0, clear skid occupancy, and present out_ctrl=CTRL_BUBBLE, out_data=0.
REQ-024 SHALL drop any in-flight entry when reset asserts mid-operation; reset overrides flush and handshakes.
REQ-025 SHALL assert in_ready=1 on the first cycle after rst_n returns to 1.

Configuration
REQ-026 SHALL compile in a two-entry skid buffer when macro PIPE_STAGE_SKID_EN is defined.
REQ-027 With PIPE_STAGE_SKID_EN: in_ready SHALL be a register output equal to "skid entry empty"; an entry accepted while head valid and out_ready=0 SHALL go to the skid; on transfer the skid SHALL move to head the same edge; full throughput (one entry/cycle) sustained with out_ready held 1.
REQ-028 Without PIPE_STAGE_SKID_EN: single head register only; in_ready SHALL be combinational: !out_valid || out_ready.
REQ-029 Both builds SHALL present identical out_* sequences for any stimulus in which out_ready never deasserts.

Verification
REQ-030 Reset then stream in_ctrl=0x001..0x005, out_ready=1 -> out_valid rises one cycle after first accept, out_ctrl=0x001..0x005 on consecutive cycles, then CTRL_BUBBLE.
REQ-031 Head holds 0x0AA, out_ready=0, in_valid=1 with 0x0BB -> skid build: in_ready=1 one cycle then 0, 0x0AA held; no-skid build: in_ready=0; after out_ready=1 both give 0x0AA then 0x0BB.
REQ-032 Head and skid full, flush=1 with in_valid=1 in_ctrl=0x3FF -> next cycle out_valid=0, out_ctrl=0x000, in_ready=1; 0x3FF never appears.
REQ-033 rst_n=0 for one cycle while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_ctrl=CTRL_BUBBLE.
REQ-034 Random in_valid/out_ready at 50% for 10,000 cycles, CTRL_WIDTH=10, DATA_WIDTH=64 -> scoreboard order exact, no loss, no duplicate, out_* stable under backpressure.
